// File: rtl/clap_toggle_light_pkg.sv
// Shared definitions for the clap toggle light: state encoding, default
// thresholds and the width helpers used to size counters.
package clap_toggle_light_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_LOCKOUT = 2'd2;

  // GAP_MAX tracks the upstream detector's sample threshold.
  localparam int unsigned CLAPS_SAMPLE_THRESHOLD = 40;
  localparam int unsigned DEF_CLAPS_OUT_WIDTH    = 16;
  localparam int unsigned DEF_CLAPS_REQUIRED     = 2;
  localparam int unsigned DEF_GAP_MIN            = 4;
  localparam int unsigned DEF_GAP_MAX            = CLAPS_SAMPLE_THRESHOLD;
  localparam int unsigned DEF_ARM_TIMEOUT        = 50000000;
  localparam int unsigned DEF_LOCKOUT_CYCLES     = 25000000;

  // Bits needed to hold the value itself, so a counter can hold its full load value.
  function automatic int clogb2(input int unsigned value);
    int result;
    result = 1;
    for (int i = 0; i < 32; i++) begin
      if ((value >> i) != 0) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/clap_toggle_light_cycle_timer.sv
// Loadable down-counter; expired_o flags the decrement that takes the count to zero.
module cycle_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             dec_i,
  output logic             expired_o
);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (load_i) begin
      value_d = load_value_i;
    end else if (dec_i && (value_q != '0)) begin
      value_d = value_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign expired_o = dec_i && !load_i && (value_q <= WIDTH'(1));

endmodule

// File: rtl/clap_toggle_light.sv
// Counts correctly spaced claps and toggles the light once a full sequence
// arrives, then ignores claps for a lockout period.
module clap_toggle_light
  import clap_toggle_light_pkg::*;
#(
  parameter int unsigned CLAPS_OUT_WIDTH = DEF_CLAPS_OUT_WIDTH,
  parameter int unsigned CLAPS_REQUIRED  = DEF_CLAPS_REQUIRED,
  parameter int unsigned GAP_MIN         = DEF_GAP_MIN,
  parameter int unsigned GAP_MAX         = DEF_GAP_MAX,
  parameter int unsigned ARM_TIMEOUT     = DEF_ARM_TIMEOUT,
  parameter int unsigned LOCKOUT_CYCLES  = DEF_LOCKOUT_CYCLES,
  parameter bit          INITIAL_STATE   = 1'b0
) (
  input  logic                              clock,
  input  logic                              nreset,
  input  logic [CLAPS_OUT_WIDTH-1:0]        claps_data,
  input  logic                              claps_valid,
  output logic                              claps_ready,
  output logic                              toglite_state,
  output logic                              toggle_pulse,
  output logic [clogb2(CLAPS_REQUIRED):0]   clap_count
);

  localparam int COUNT_W = clogb2(CLAPS_REQUIRED) + 1;
  localparam int TIMER_W = clogb2(max_u(ARM_TIMEOUT, LOCKOUT_CYCLES));

  localparam logic [CLAPS_OUT_WIDTH-1:0] GAP_MIN_V   = CLAPS_OUT_WIDTH'(GAP_MIN);
  localparam logic [CLAPS_OUT_WIDTH-1:0] GAP_MAX_V   = CLAPS_OUT_WIDTH'(GAP_MAX);
  localparam logic [COUNT_W-1:0]         REQUIRED_V  = COUNT_W'(CLAPS_REQUIRED);
  localparam logic [TIMER_W-1:0]         ARM_LOAD    = TIMER_W'(ARM_TIMEOUT);
  localparam logic [TIMER_W-1:0]         LOCKOUT_LOAD = TIMER_W'(LOCKOUT_CYCLES);

  logic [1:0]         state_q, state_d;
  logic [COUNT_W-1:0] clapCount_q, clapCount_d;
  logic               lightState_q, lightState_d;
  logic               togglePulse_q, togglePulse_d;
  logic               ready_q;

  logic               beat;
  logic               doToggle;
  logic [COUNT_W-1:0] countInc;
  logic               timerLoad;
  logic [TIMER_W-1:0] timerLoadValue;
  logic               timerDec;
  logic               timerExpired;

  assign beat     = claps_valid && ready_q;
  assign countInc = clapCount_q + COUNT_W'(1);

  cycle_timer #(
    .WIDTH(TIMER_W)
  ) u_timer (
    .clock        (clock),
    .nreset       (nreset),
    .load_i       (timerLoad),
    .load_value_i (timerLoadValue),
    .dec_i        (timerDec),
    .expired_o    (timerExpired)
  );

  // A beat in ARMED takes priority over a coincident timeout; in LOCKOUT it is simply dropped.
  always_comb begin
    state_d        = state_q;
    clapCount_d    = clapCount_q;
    lightState_d   = lightState_q;
    togglePulse_d  = 1'b0;
    timerLoad      = 1'b0;
    timerLoadValue = ARM_LOAD;
    timerDec       = 1'b0;
    doToggle       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (beat) begin
          if (CLAPS_REQUIRED <= 1) begin
            doToggle = 1'b1;
          end else begin
            clapCount_d = COUNT_W'(1);
            timerLoad   = 1'b1;
            state_d     = ST_ARMED;
          end
        end
      end

      ST_ARMED: begin
        if (beat) begin
          if (claps_data < GAP_MIN_V) begin
            clapCount_d = clapCount_q;
          end else if (claps_data <= GAP_MAX_V) begin
            if (countInc >= REQUIRED_V) begin
              doToggle = 1'b1;
            end else begin
              clapCount_d = countInc;
              timerLoad   = 1'b1;
            end
          end else begin
            clapCount_d = COUNT_W'(1);
            timerLoad   = 1'b1;
          end
        end else begin
          timerDec = 1'b1;
          if (timerExpired) begin
            clapCount_d = '0;
            state_d     = ST_IDLE;
          end
        end
      end

      ST_LOCKOUT: begin
        timerDec = 1'b1;
        if (timerExpired) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        clapCount_d = '0;
        state_d     = ST_IDLE;
      end
    endcase

    if (doToggle) begin
      lightState_d   = ~lightState_q;
      togglePulse_d  = 1'b1;
      clapCount_d    = '0;
      timerLoad      = 1'b1;
      timerLoadValue = LOCKOUT_LOAD;
      state_d        = ST_LOCKOUT;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q       <= ST_IDLE;
      clapCount_q   <= '0;
      lightState_q  <= INITIAL_STATE;
      togglePulse_q <= 1'b0;
      ready_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      clapCount_q   <= clapCount_d;
      lightState_q  <= lightState_d;
      togglePulse_q <= togglePulse_d;
      ready_q       <= 1'b1;
    end
  end

  assign claps_ready   = ready_q;
  assign toglite_state = lightState_q;
  assign toggle_pulse  = togglePulse_q;
  assign clap_count    = clapCount_q;

endmodule

// File: tb/tb_clap_toggle_light.sv
// Directed bench for clap_toggle_light: vector table for clap sequences plus
// hand-written sequences for timeout, lockout and asynchronous reset.
module tb_clap_toggle_light;
  import clap_toggle_light_pkg::*;

  localparam int REQ = 2;

  logic                  clock;
  logic                  nreset;
  logic [15:0]           claps_data;
  logic                  claps_valid;
  logic                  claps_ready;
  logic                  toglite_state;
  logic                  toggle_pulse;
  logic [clogb2(REQ):0]  clap_count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          idleBefore;
    bit          valid;
    logic [15:0] data;
    bit          expLite;
    bit          expPulse;
    int          expCount;
  } vec_t;

  vec_t vecs[$];

  clap_toggle_light #(
    .CLAPS_OUT_WIDTH (16),
    .CLAPS_REQUIRED  (REQ),
    .GAP_MIN         (4),
    .GAP_MAX         (40),
    .ARM_TIMEOUT     (100),
    .LOCKOUT_CYCLES  (50),
    .INITIAL_STATE   (1'b0)
  ) dut (
    .clock         (clock),
    .nreset        (nreset),
    .claps_data    (claps_data),
    .claps_valid   (claps_valid),
    .claps_ready   (claps_ready),
    .toglite_state (toglite_state),
    .toggle_pulse  (toggle_pulse),
    .clap_count    (clap_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drives one cycle of input and returns just after the edge that samples it.
  task automatic applyStimulus(input bit v, input logic [15:0] d);
    @(negedge clock);
    claps_valid = v;
    claps_data  = d;
    @(posedge clock);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'd0);
  endtask

  task automatic checkAll(input string tag, input int lite, input int pulse, input int cnt);
    checkOutput({tag, ".lite"},  toglite_state, lite);
    checkOutput({tag, ".pulse"}, toggle_pulse, pulse);
    checkOutput({tag, ".count"}, clap_count, cnt);
    checkOutput({tag, ".ready"}, claps_ready, 1);
  endtask

  initial begin
    nreset      = 1'b0;
    claps_valid = 1'b0;
    claps_data  = '0;

    // basic pair, echo, inclusive bounds, oversized and saturated gaps
    vecs.push_back('{0,  1'b1, 16'd0,     1'b0, 1'b0, 1});
    vecs.push_back('{9,  1'b1, 16'd20,    1'b1, 1'b1, 0});
    vecs.push_back('{0,  1'b0, 16'd0,     1'b1, 1'b0, 0});
    vecs.push_back('{60, 1'b1, 16'd5,     1'b1, 1'b0, 1});
    vecs.push_back('{2,  1'b1, 16'd2,     1'b1, 1'b0, 1});
    vecs.push_back('{2,  1'b1, 16'd40,    1'b0, 1'b1, 0});
    vecs.push_back('{0,  1'b0, 16'd0,     1'b0, 1'b0, 0});
    vecs.push_back('{60, 1'b1, 16'd0,     1'b0, 1'b0, 1});
    vecs.push_back('{0,  1'b1, 16'd3,     1'b0, 1'b0, 1});
    vecs.push_back('{0,  1'b1, 16'd4,     1'b1, 1'b1, 0});
    vecs.push_back('{0,  1'b0, 16'd0,     1'b1, 1'b0, 0});
    vecs.push_back('{60, 1'b1, 16'd0,     1'b1, 1'b0, 1});
    vecs.push_back('{3,  1'b1, 16'd41,    1'b1, 1'b0, 1});
    vecs.push_back('{0,  1'b1, 16'hFFFF,  1'b1, 1'b0, 1});
    vecs.push_back('{0,  1'b1, 16'd10,    1'b0, 1'b1, 0});
    vecs.push_back('{0,  1'b0, 16'd0,     1'b0, 1'b0, 0});

    #12;
    checkOutput("reset.ready", claps_ready, 0);
    checkOutput("reset.lite",  toglite_state, 0);
    checkOutput("reset.pulse", toggle_pulse, 0);
    checkOutput("reset.count", clap_count, 0);
    @(negedge clock);
    nreset = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("release.ready", claps_ready, 1);

    foreach (vecs[i]) begin
      idleCycles(vecs[i].idleBefore);
      applyStimulus(vecs[i].valid, vecs[i].data);
      checkAll($sformatf("vec%0d", i), vecs[i].expLite, vecs[i].expPulse, vecs[i].expCount);
    end

    // Timeout: 100 idle cycles drop the partial sequence.
    idleCycles(60);
    applyStimulus(1'b1, 16'd0);
    checkAll("to.first", 0, 0, 1);
    idleCycles(99);
    checkOutput("to.before_expiry.count", clap_count, 1);
    idleCycles(1);
    checkOutput("to.expired.count", clap_count, 0);
    applyStimulus(1'b1, 16'd10);
    checkAll("to.restart", 0, 0, 1);
    idleCycles(99);
    applyStimulus(1'b1, 16'd10);
    checkAll("to.beat_on_expiry", 1, 1, 0);

    // Lockout: beats at 5, 20 and 50 cycles after the toggle are discarded.
    idleCycles(4);
    applyStimulus(1'b1, 16'd10);
    checkAll("lock.at5", 1, 0, 0);
    idleCycles(14);
    applyStimulus(1'b1, 16'd10);
    checkAll("lock.at20", 1, 0, 0);
    idleCycles(29);
    applyStimulus(1'b1, 16'd10);
    checkAll("lock.at_expiry", 1, 0, 0);
    applyStimulus(1'b1, 16'd0);
    checkAll("lock.after_first", 1, 0, 1);
    idleCycles(5);
    applyStimulus(1'b1, 16'd10);
    checkAll("lock.after_toggle", 0, 1, 0);

    // Asynchronous reset mid-lockout, right as the pulse is high.
    idleCycles(60);
    applyStimulus(1'b1, 16'd0);
    applyStimulus(1'b1, 16'd10);
    checkOutput("rst_lock.pre.lite", toglite_state, 1);
    #1 nreset = 1'b0;
    #1;
    checkOutput("rst_lock.lite",  toglite_state, 0);
    checkOutput("rst_lock.pulse", toggle_pulse, 0);
    checkOutput("rst_lock.count", clap_count, 0);
    checkOutput("rst_lock.ready", claps_ready, 0);
    @(negedge clock);
    nreset = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("rst_lock.release.ready", claps_ready, 1);

    // Asynchronous reset mid-ARMED with the light on.
    applyStimulus(1'b1, 16'd0);
    applyStimulus(1'b1, 16'd10);
    checkAll("rst_arm.toggle", 1, 1, 0);
    idleCycles(60);
    applyStimulus(1'b1, 16'd0);
    checkAll("rst_arm.armed", 1, 0, 1);
    #1 nreset = 1'b0;
    #1;
    checkOutput("rst_arm.lite",  toglite_state, 0);
    checkOutput("rst_arm.count", clap_count, 0);
    checkOutput("rst_arm.ready", claps_ready, 0);
    @(negedge clock);
    nreset = 1'b1;
    claps_valid = 1'b0;
    @(posedge clock);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
